ysyx_23060236_trap_ctrl: RTL



---
 rtl/ysyx_23060236_trap_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060236_trap_ctrl.sv
// Trap sequencer: arbitrates trap/mret/interrupt requests and drives the CSR write port and IFU redirect.
// Optional feature macro: YSYX_23060236_TRAP_IRQ_EN enables machine-timer interrupt arbitration.
module ysyx_23060236_trap_ctrl #(
    parameter logic [31:0] RESET_PC_UNUSED = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_type,
    input  logic [31:0] req_pc,
    input  logic        irq,
    input  logic [31:0] irq_pc,
    input  logic [31:0] csr_mstatus,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    output logic        csr_wen,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        busy
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CSR_AW = 12;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

    localparam logic [XLEN-1:0] CAUSE_ECALL   = 32'd11;
    localparam logic [XLEN-1:0] CAUSE_EBREAK  = 32'd3;
    localparam logic [XLEN-1:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [XLEN-1:0] CAUSE_IRQ     = 32'h8000_0007;

    localparam logic [1:0] REQ_ECALL  = 2'b00;
    localparam logic [1:0] REQ_MRET   = 2'b01;
    localparam logic [1:0] REQ_EBREAK = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_EPC,
        S_W_CAUSE,
        S_W_STATUS,
        S_REDIRECT
    } state_e;

    state_e            state_q, state_d;
    logic              mret_q, mret_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic [XLEN-1:0]   cause_q, cause_d;
    logic [XLEN-1:0]   mstatus_q, mstatus_d;
    logic [XLEN-1:0]   target_q, target_d;

    logic              take_irq;
    logic              req_ready_d, busy_d, csr_wen_d, redirect_valid_d;
    logic [CSR_AW-1:0] csr_waddr_d;
    logic [XLEN-1:0]   csr_wdata_d, redirect_pc_d;

    // Trap entry: stack MIE into MPIE, disable interrupts, record M-mode as previous privilege.
    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r        = ms;
        r[7]     = ms[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r        = ms;
        r[3]     = ms[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

`ifdef YSYX_23060236_TRAP_IRQ_EN
    assign take_irq = !req_valid && irq && csr_mstatus[3];
`else
    logic unused_irq;
    assign unused_irq = ^{irq, irq_pc};
    assign take_irq   = 1'b0;
`endif

    // Next state and capture of request context at accept.
    always_comb begin
        state_d   = state_q;
        mret_d    = mret_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        mstatus_d = mstatus_q;
        target_d  = target_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid || take_irq) begin
                    mret_d    = req_valid && (req_type == REQ_MRET);
                    mstatus_d = csr_mstatus;
                    if (req_valid) begin
                        epc_d = req_pc;
                        case (req_type)
                            REQ_ECALL:  cause_d = CAUSE_ECALL;
                            REQ_EBREAK: cause_d = CAUSE_EBREAK;
                            REQ_MRET:   cause_d = '0;
                            default:    cause_d = CAUSE_ILLEGAL;
                        endcase
                    end else begin
                        epc_d   = irq_pc;
                        cause_d = CAUSE_IRQ;
                    end
                    if (mret_d) begin
                        target_d = csr_mepc;
                        state_d  = S_W_STATUS;
                    end else begin
                        target_d = csr_mtvec;
                        state_d  = S_W_EPC;
                    end
                end
            end
            S_W_EPC:    state_d = S_W_CAUSE;
            S_W_CAUSE:  state_d = S_W_STATUS;
            S_W_STATUS: state_d = S_REDIRECT;
            S_REDIRECT: if (redirect_ready) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state so they can be registered with no added latency.
    always_comb begin
        req_ready_d      = (state_d == S_IDLE);
        busy_d           = (state_d != S_IDLE);
        csr_wen_d        = 1'b0;
        csr_waddr_d      = '0;
        csr_wdata_d      = '0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = RESET_PC_UNUSED;
        case (state_d)
            S_W_EPC: begin
                csr_wen_d   = 1'b1;
                csr_waddr_d = CSR_MEPC;
                csr_wdata_d = epc_d;
            end
            S_W_CAUSE: begin
                csr_wen_d   = 1'b1;
                csr_waddr_d = CSR_MCAUSE;
                csr_wdata_d = cause_d;
            end
            S_W_STATUS: begin
                csr_wen_d   = 1'b1;
                csr_waddr_d = CSR_MSTATUS;
                csr_wdata_d = mret_d ? mret_mstatus(mstatus_d) : trap_mstatus(mstatus_d);
            end
            S_REDIRECT: begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = target_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            mret_q         <= 1'b0;
            epc_q          <= '0;
            cause_q        <= '0;
            mstatus_q      <= '0;
            target_q       <= '0;
            req_ready      <= 1'b1;
            busy           <= 1'b0;
            csr_wen        <= 1'b0;
            csr_waddr      <= '0;
            csr_wdata      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= RESET_PC_UNUSED;
        end else begin
            state_q        <= state_d;
            mret_q         <= mret_d;
            epc_q          <= epc_d;
            cause_q        <= cause_d;
            mstatus_q      <= mstatus_d;
            target_q       <= target_d;
            req_ready      <= req_ready_d;
            busy           <= busy_d;
            csr_wen        <= csr_wen_d;
            csr_waddr      <= csr_waddr_d;
            csr_wdata      <= csr_wdata_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
        end
    end

endmodule
